seg7_scan_driver: RTL and testbench

Synthesisable, parametrised successor to the team's 4-digit hex seven-segment encoder. It time-multiplexes DIGITS hex nibbles onto one shared segment bus using a clock-divided scan counter instead of simulation delays. It adds per-digit decimal points, leading-zero blanking, tear-free frame-synchronous data update, inter-digit ghost blanking and selectable output polarity. It sits between the arithmetic datapath (for example, divider results) and the board display pins.

---
 rtl/seg7_scan_driver.sv | 159 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed hex seven-segment driver: scans DIGITS nibbles onto one segment bus
// with per-digit decimal points, leading-zero blanking, frame-synchronous update,
// a blank cycle at the start of every slot and configurable output polarity.
module seg7_scan_driver #(
    parameter int unsigned DIGITS          = 4,
    parameter int unsigned SCAN_DIV        = 50000,
    parameter bit          SEG_ACTIVE_HIGH = 1'b1,
    parameter bit          SEL_ACTIVE_HIGH = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  en,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     sel,
    output logic                  frame_done
);

    localparam int unsigned DATA_W = 4 * DIGITS;
    localparam int unsigned CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [6:0]        SEG_OFF  = SEG_ACTIVE_HIGH ? 7'b0000000 : 7'b1111111;
    localparam logic              DP_OFF   = ~SEG_ACTIVE_HIGH;
    localparam logic [DIGITS-1:0] SEL_OFF  = SEL_ACTIVE_HIGH ? '0 : '1;

    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] disp_data;
    logic [DIGITS-1:0] disp_dp;
    logic [DATA_W-1:0] pend_data;
    logic [DIGITS-1:0] pend_dp;
    logic              pend_v;

    logic              slot_end_c;
    logic              boundary_c;
    logic [DIGITS-1:0] lz_mask_c;
    logic              zero_above_c;
    logic [3:0]        cur_nib_c;
    logic              cur_dp_c;
    logic              cur_lz_c;
    logic [6:0]        seg_lit_c;
    logic [DIGITS-1:0] sel_hot_c;

    // Hex nibble to active-high {g,f,e,d,c,b,a} pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        hex_to_seg = 7'b0000000;
        case (v)
            4'h0: hex_to_seg = 7'b0111111;
            4'h1: hex_to_seg = 7'b0000110;
            4'h2: hex_to_seg = 7'b1011011;
            4'h3: hex_to_seg = 7'b1001111;
            4'h4: hex_to_seg = 7'b1100110;
            4'h5: hex_to_seg = 7'b1101101;
            4'h6: hex_to_seg = 7'b1111101;
            4'h7: hex_to_seg = 7'b0000111;
            4'h8: hex_to_seg = 7'b1111111;
            4'h9: hex_to_seg = 7'b1101111;
            4'hA: hex_to_seg = 7'b1110111;
            4'hB: hex_to_seg = 7'b1111100;
            4'hC: hex_to_seg = 7'b0111001;
            4'hD: hex_to_seg = 7'b1011110;
            4'hE: hex_to_seg = 7'b1111001;
            4'hF: hex_to_seg = 7'b1110001;
            default: hex_to_seg = 7'b0000000;
        endcase
    endfunction

    assign slot_end_c = en && (cnt == CNT_LAST);
    assign boundary_c = slot_end_c && (idx == IDX_LAST);
    assign sel_hot_c  = DIGITS'(1) << idx;

    // Mark digits that sit above the most significant non-zero nibble; digit 0 never qualifies.
    always_comb begin
        lz_mask_c    = '0;
        zero_above_c = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
            zero_above_c = zero_above_c && (disp_data[4*k +: 4] == 4'h0);
            lz_mask_c[k] = zero_above_c;
        end
    end

    // Pick the nibble, decimal point and blanking flag of the digit being scanned.
    always_comb begin
        cur_nib_c = 4'h0;
        cur_dp_c  = 1'b0;
        cur_lz_c  = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nib_c = disp_data[4*k +: 4];
                cur_dp_c  = disp_dp[k];
                cur_lz_c  = lz_mask_c[k];
            end
        end
        seg_lit_c = (blank_lz && cur_lz_c) ? 7'b0000000 : hex_to_seg(cur_nib_c);
    end

    // Slot counter and digit index; frame_done marks the edge after the last slot of a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary_c;
            if (en) begin
                if (cnt == CNT_LAST) begin
                    cnt <= '0;
                    idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    // Pending capture and frame-synchronous transfer to the displayed value.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_data <= '0;
            disp_dp   <= '0;
            pend_data <= '0;
            pend_dp   <= '0;
            pend_v    <= 1'b0;
        end else begin
            if (boundary_c && pend_v) begin
                disp_data <= pend_data;
                disp_dp   <= pend_dp;
                pend_v    <= 1'b0;
            end
            // A load in the boundary cycle re-arms pending after the old value moved across.
            if (load) begin
                pend_data <= data;
                pend_dp   <= dp_in;
                pend_v    <= 1'b1;
            end
        end
    end

    // Registered pin drive: inactive in reset, while disabled and in each slot's blank cycle.
    always_ff @(posedge clk) begin
        if (rst || !en || (cnt == '0)) begin
            sel <= SEL_OFF;
            seg <= SEG_OFF;
            dp  <= DP_OFF;
        end else begin
            sel <= SEL_ACTIVE_HIGH ? sel_hot_c : ~sel_hot_c;
            seg <= SEG_ACTIVE_HIGH ? seg_lit_c : ~seg_lit_c;
            dp  <= SEG_ACTIVE_HIGH ? cur_dp_c : ~cur_dp_c;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (active-high and fully inverted polarity)
// share stimulus; a per-cycle scoreboard plus table vectors and corner sequences.
module tb_seg7_scan_driver;

    localparam int unsigned D     = 4;
    localparam int unsigned S     = 4;
    localparam int unsigned FRAME = D * S;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic        load;
    logic        en;
    logic        blank_lz;

    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [3:0]  sel_a, sel_b;
    logic        fd_a, fd_b;

    seg7_scan_driver #(
        .DIGITS(D), .SCAN_DIV(S), .SEG_ACTIVE_HIGH(1'b1), .SEL_ACTIVE_HIGH(1'b1)
    ) u_dut (
        .clk(clk), .rst(rst), .data(data), .dp_in(dp_in), .load(load), .en(en),
        .blank_lz(blank_lz), .seg(seg_a), .dp(dp_a), .sel(sel_a), .frame_done(fd_a)
    );

    seg7_scan_driver #(
        .DIGITS(D), .SCAN_DIV(S), .SEG_ACTIVE_HIGH(1'b0), .SEL_ACTIVE_HIGH(1'b0)
    ) u_inv (
        .clk(clk), .rst(rst), .data(data), .dp_in(dp_in), .load(load), .en(en),
        .blank_lz(blank_lz), .seg(seg_b), .dp(dp_b), .sel(sel_b), .frame_done(fd_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sel;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dpv;
        logic        blz;
        logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    exp_t sb_q[$];
    vec_t vt[8];

    int checks = 0;
    int errors = 0;

    // Reference state
    int          mcnt, midx;
    logic [15:0] mdisp, mpend;
    logic [3:0]  mdpd, mpdp;
    logic        mpv;

    // Per-digit observation on the active-high instance: {seen, dp, seg}
    logic [8:0]  got[4];

    function automatic logic [6:0] enc(input logic [3:0] v);
        case (v)
            4'h0: enc = 7'b0111111;  4'h1: enc = 7'b0000110;
            4'h2: enc = 7'b1011011;  4'h3: enc = 7'b1001111;
            4'h4: enc = 7'b1100110;  4'h5: enc = 7'b1101101;
            4'h6: enc = 7'b1111101;  4'h7: enc = 7'b0000111;
            4'h8: enc = 7'b1111111;  4'h9: enc = 7'b1101111;
            4'hA: enc = 7'b1110111;  4'hB: enc = 7'b1111100;
            4'hC: enc = 7'b0111001;  4'hD: enc = 7'b1011110;
            4'hE: enc = 7'b1111001;  default: enc = 7'b1110001;
        endcase
    endfunction

    function automatic int mpos();
        return midx * int'(S) + mcnt;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // Advance the reference by one clock edge and queue the outputs that edge must produce.
    task automatic model_step();
        exp_t e;
        logic bnd;
        e = '{sel: 4'h0, seg: 7'h00, dp: 1'b0, fd: 1'b0};
        if (rst) begin
            mcnt = 0; midx = 0; mdisp = '0; mdpd = '0; mpend = '0; mpdp = '0; mpv = 1'b0;
        end else begin
            if (en && mcnt != 0) begin
                e.sel = 4'(1) << midx;
                if (blank_lz && midx != 0 && ((mdisp >> (4 * midx)) == 16'h0))
                    e.seg = 7'h00;
                else
                    e.seg = enc(mdisp[4*midx +: 4]);
                e.dp = mdpd[midx];
            end
            bnd  = en && (mcnt == int'(S) - 1) && (midx == int'(D) - 1);
            e.fd = bnd;
            if (bnd && mpv) begin mdisp = mpend; mdpd = mpdp; mpv = 1'b0; end
            if (load) begin mpend = data; mpdp = dp_in; mpv = 1'b1; end
            if (en) begin
                if (mcnt == int'(S) - 1) begin mcnt = 0; midx = (midx + 1) % int'(D); end
                else mcnt++;
            end
        end
        sb_q.push_back(e);
    endtask

    // Pop the expected outputs for the last edge and compare both instances.
    task automatic check_out();
        exp_t e;
        logic [3:0] isel;
        logic [6:0] iseg;
        logic       idp;
        if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty at %0t: got 0 expected 1", $time);
            return;
        end
        e = sb_q.pop_front();
        isel = ~e.sel; iseg = ~e.seg; idp = ~e.dp;
        chk("sel", 32'(sel_a), 32'(e.sel));
        chk("seg", 32'(seg_a), 32'(e.seg));
        chk("dp", 32'(dp_a), 32'(e.dp));
        chk("frame_done", 32'(fd_a), 32'(e.fd));
        chk("inv_sel", 32'(sel_b), 32'(isel));
        chk("inv_seg", 32'(seg_b), 32'(iseg));
        chk("inv_dp", 32'(dp_b), 32'(idp));
        chk("inv_frame_done", 32'(fd_b), 32'(e.fd));
        for (int k = 0; k < int'(D); k++)
            if (sel_a == 4'(1) << k) got[k] = {1'b1, dp_a, seg_a};
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_out();
    endtask

    task automatic clear_got();
        for (int k = 0; k < int'(D); k++) got[k] = '0;
    endtask

    task automatic wait_pos(input int target);
        int b = 0;
        while (mpos() != target) begin
            tick();
            b++;
            if (b > 200) begin
                checks++; errors++;
                $display("FAIL wait_pos timeout: got %0d expected %0d", mpos(), target);
                return;
            end
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        data = d; dp_in = p; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Run until the pending value has been transferred; leaves the scan at the start of a frame.
    task automatic settle();
        int b = 0;
        while (mpv) begin
            tick();
            b++;
            if (b > 100) begin
                checks++; errors++;
                $display("FAIL settle timeout: got %0d expected %0d", mpv, 0);
                return;
            end
        end
    endtask

    task automatic run_frame();
        clear_got();
        repeat (FRAME) tick();
    endtask

    task automatic chk_digit(input string name, input int k, input logic [6:0] s, input logic d);
        chk(name, 32'(got[k]), 32'({1'b1, d, s}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        vt[0] = '{16'h1A3F, 4'b0000, 1'b0, {7'b0000110, 7'b1110111, 7'b1001111, 7'b1110001}};
        vt[1] = '{16'h0050, 4'b1000, 1'b1, {7'b0000000, 7'b0000000, 7'b1101101, 7'b0111111}};
        vt[2] = '{16'h0000, 4'b0000, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b0111111}};
        vt[3] = '{16'h0008, 4'b0000, 1'b0, {7'b0111111, 7'b0111111, 7'b0111111, 7'b1111111}};
        vt[4] = '{16'h1234, 4'b0101, 1'b0, {7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110}};
        vt[5] = '{16'hBCDE, 4'b0000, 1'b1, {7'b1111100, 7'b0111001, 7'b1011110, 7'b1111001}};
        vt[6] = '{16'h0906, 4'b0010, 1'b1, {7'b0000000, 7'b1101111, 7'b0111111, 7'b1111101}};
        vt[7] = '{16'h5678, 4'b1111, 1'b0, {7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111}};

        rst = 1'b1; en = 1'b1; load = 1'b0; blank_lz = 1'b0; data = '0; dp_in = '0;
        mcnt = 0; midx = 0; mdisp = '0; mpend = '0; mdpd = '0; mpdp = '0; mpv = 1'b0;
        clear_got();

        // Reset held with en=1
        repeat (3) begin
            tick();
            chk("rst_sel", 32'(sel_a), 32'h0);
            chk("rst_seg", 32'(seg_a), 32'h0);
            chk("rst_fd", 32'(fd_a), 32'h0);
        end
        rst = 1'b0;
        tick();
        chk("first_blank_sel", 32'(sel_a), 32'h0);
        tick();
        chk("first_active_sel", 32'(sel_a), 32'b0001);
        chk("first_active_seg", 32'(seg_a), 32'(7'b0111111));

        // frame_done rate: one pulse per FRAME cycles
        pulses = 0;
        repeat (4 * FRAME) begin
            tick();
            if (fd_a) pulses++;
        end
        chk("frame_done_count", 32'(pulses), 32'd4);

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            blank_lz = vt[i].blz;
            do_load(vt[i].data, vt[i].dpv);
            settle();
            run_frame();
            for (int k = 0; k < int'(D); k++)
                chk_digit($sformatf("vec%0d_digit%0d", i, k), k, vt[i].segs[7*k +: 7], vt[i].dpv[k]);
        end

        // Tear-free update mid-frame
        blank_lz = 1'b0;
        do_load(16'h1234, 4'b0000);
        settle();
        wait_pos(5);
        do_load(16'h0000, 4'b0000);
        clear_got();
        wait_pos(0);
        chk("tear_d0_not_shown", 32'(got[0][8]), 32'h0);
        chk_digit("tear_d1_old", 1, 7'b1001111, 1'b0);
        chk_digit("tear_d2_old", 2, 7'b1011011, 1'b0);
        chk_digit("tear_d3_old", 3, 7'b0000110, 1'b0);
        run_frame();
        chk_digit("tear_d0_new", 0, 7'b0111111, 1'b0);

        // Inverted polarity and enable freeze across the frame boundary
        do_load(16'h0008, 4'b0000);
        settle();
        wait_pos(2);
        chk("inv_d0_sel", 32'(sel_b), 32'b1110);
        chk("inv_d0_seg", 32'(seg_b), 32'(7'b0000000));
        wait_pos(int'(FRAME) - 1);
        en = 1'b0;
        repeat (10) begin
            tick();
            chk("en0_sel", 32'(sel_a), 32'h0);
            chk("en0_inv_sel", 32'(sel_b), 32'hF);
            chk("en0_inv_seg", 32'(seg_b), 32'h7F);
            chk("en0_fd", 32'(fd_a), 32'h0);
        end
        en = 1'b1;
        tick();
        chk("resume_sel", 32'(sel_a), 32'b1000);
        chk("resume_fd", 32'(fd_a), 32'h1);

        // Load coincident with the frame boundary
        do_load(16'h1111, 4'b0000);
        wait_pos(int'(FRAME) - 1);
        do_load(16'h2222, 4'b0000);
        run_frame();
        chk_digit("collide_old", 0, 7'b0000110, 1'b0);
        run_frame();
        chk_digit("collide_new", 0, 7'b1011011, 1'b0);

        // Back-to-back loads: the last one wins
        do_load(16'h3333, 4'b0000);
        do_load(16'h4444, 4'b0000);
        do_load(16'h5555, 4'b0000);
        settle();
        run_frame();
        chk_digit("b2b_last", 0, 7'b1101101, 1'b0);

        // Reset mid-slot with a pending load
        do_load(16'h7777, 4'b0000);
        wait_pos(6);
        rst = 1'b1;
        tick();
        chk("midrst_sel", 32'(sel_a), 32'h0);
        chk("midrst_seg", 32'(seg_a), 32'h0);
        chk("midrst_inv_sel", 32'(sel_b), 32'hF);
        rst = 1'b0;
        run_frame();
        chk_digit("midrst_d0", 0, 7'b0111111, 1'b0);
        chk_digit("midrst_d3", 3, 7'b0111111, 1'b0);
        run_frame();
        chk_digit("midrst_discard", 3, 7'b0111111, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
